spi_xact_arb: RTL and testbench
===============================

SPI_XACT_ARB -- requirements
Module: spi_xact_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, the number of requesters.
REQ-002 The block SHALL have parameter NUM_SS, default 5, the number of slave selects.
REQ-003 The block SHALL have parameter CMD_W, default 16, the SPI command and read-data width.
REQ-004 The block SHALL have parameter GUARD, default 2, the number of idle cycles with all selects high between transactions.
REQ-005 The block SHALL derive SS_W = max(1, clog2(NUM_SS)) as a local constant.
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 req  input  NUM_REQ  per-requester transaction request, level, held until gnt.
REQ-009 req_ss  input  NUM_REQ*SS_W  target select index per requester; requester i uses slice [i*SS_W +: SS_W].
REQ-010 req_cmd  input  NUM_REQ*CMD_W  command word per requester; requester i uses slice [i*CMD_W +: CMD_W].
REQ-011 gnt  output  NUM_REQ  one-cycle one-hot pulse marking acceptance of a request.
REQ-012 done  output  NUM_REQ  one-cycle pulse to the owning requester on completion.
REQ-013 rd_data  output  CMD_W  last SPI read word, held until the next capture.
REQ-014 err  output  1  one-cycle pulse when a granted request has req_ss >= NUM_SS.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 wrt_SPI  output  1  one-cycle start pulse to the SPI master.
REQ-017 SPI_cmd  output  CMD_W  command word to the SPI master, registered.
REQ-018 SPI_done  input  1  completion pulse from the SPI master.
REQ-019 SPI_data_out  input  CMD_W  read word from the SPI master, valid when SPI_done is high.
REQ-020 ss_n  output  NUM_SS  active-low slave selects, registered, at most one low at a time.

Function
REQ-021 The state machine SHALL have four states, IDLE, SEL, XFER and GAP, and all outputs SHALL be registered.
REQ-022 Arbitration in IDLE SHALL be round-robin: the requester after the last granted index has the highest priority, with requester 0 highest after reset.
REQ-023 req SHALL be sampled only in IDLE, and gnt SHALL pulse in the same edge that latches the owner, ss index and cmd into SPI_cmd.
REQ-024 For a valid ss index, the transition IDLE->SEL SHALL drive ss_n[idx] low from the next cycle.
REQ-025 In SEL, the block SHALL pulse wrt_SPI for exactly one cycle and then move to XFER.
REQ-026 The first rising edge of wrt_SPI SHALL come one cycle after ss_n falls.
REQ-027 In XFER, on SPI_done the block SHALL capture SPI_data_out into rd_data, pulse done[owner], and raise all ss_n on that same edge.
REQ-028 After XFER, the block SHALL go to GAP when GUARD > 0 and to IDLE when GUARD = 0.
REQ-029 GAP SHALL last exactly GUARD cycles, with all ss_n high and req ignored.
REQ-030 ss_n and SPI_cmd SHALL stay stable from SEL through XFER regardless of changes on req, req_ss or req_cmd.
REQ-031 For an invalid ss index (>= NUM_SS), the block SHALL pulse gnt and err together, keep ss_n all high, never pulse wrt_SPI, pulse done[owner] one cycle later, leave rd_data unchanged, and return to IDLE.
REQ-032 SPI_done received outside XFER SHALL be ignored, with no capture and no done pulse.
REQ-033 A requester that keeps req asserted after done SHALL be re-arbitrated normally and SHALL NOT gain priority over other waiting requesters.
REQ-034 Latency from req high in IDLE to the first wrt_SPI SHALL be 2 cycles, and from SPI_done to the next possible gnt SHALL be GUARD+1 cycles.
REQ-035 The block SHALL work for NUM_REQ = 1 and NUM_SS = 1.

Reset
REQ-036 While rst_n is low, the block SHALL drive ss_n all ones, wrt_SPI, gnt, done and err 0, busy 0, SPI_cmd and rd_data 0, state IDLE, and round-robin pointer 0.
REQ-037 Reset asserted mid-transaction SHALL raise all ss_n asynchronously, and no done SHALL be issued for the aborted transaction.

Verification
REQ-038 Single request: req[0]=1, req_ss=1, req_cmd=16'hA5C3 -> gnt[0]; ss_n=5'b11101 next cycle; wrt_SPI one cycle later with SPI_cmd=16'hA5C3; SPI_done with SPI_data_out=16'h1234 -> rd_data=16'h1234, done[0], ss_n=5'b11111.
REQ-039 Contention: req=2'b11 held continuously -> grants alternate 0,1,0,1, and consecutive transactions are separated by 2 GAP cycles with ss_n all high.
REQ-040 Invalid select: req_ss=7 with NUM_SS=5 -> gnt and err in the same cycle, done the next cycle, wrt_SPI never pulses, rd_data unchanged.
REQ-041 Reset in XFER: rst_n low with ss_n=5'b11110 -> ss_n=5'b11111 before the next clock edge, no done; after release, idle with busy=0.
REQ-042 Stray SPI_done in IDLE or GAP -> no done pulse and rd_data unchanged; with GUARD=0, the next gnt occurs 1 cycle after SPI_done.

Source files
------------

// File: rtl/spi_xact_arb.sv
// Round-robin arbiter that serialises requester transactions onto one SPI master.
// Each transaction drives one slave select, then holds every select high for GUARD idle cycles.
module spi_xact_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned NUM_SS  = 5,
  parameter int unsigned CMD_W   = 16,
  parameter int unsigned GUARD   = 2,
  localparam int unsigned SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SS_W-1:0]  req_ss,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [CMD_W-1:0]         rd_data,
  output logic                     err,
  output logic                     busy,
  output logic                     wrt_SPI,
  output logic [CMD_W-1:0]         SPI_cmd,
  input  logic                     SPI_done,
  input  logic [CMD_W-1:0]         SPI_data_out,
  output logic [NUM_SS-1:0]        ss_n
);

  localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEL, XFER, GAP} state_t;

  state_t               state, state_nxt;
  logic [OW-1:0]        owner, owner_nxt;
  logic [OW-1:0]        ptr, ptr_nxt;
  logic [GW-1:0]        cnt, cnt_nxt;
  logic                 bad, bad_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt, done_nxt;
  logic [CMD_W-1:0]     rd_nxt, cmd_nxt;
  logic [NUM_SS-1:0]    ss_nxt;
  logic                 err_nxt, wrt_nxt, busy_nxt;

  logic                 found;
  logic [OW-1:0]        win;
  logic [SS_W-1:0]      sel;
  int unsigned          j;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    bad_nxt   = bad;
    gnt_nxt   = '0;
    done_nxt  = '0;
    rd_nxt    = rd_data;
    cmd_nxt   = SPI_cmd;
    ss_nxt    = ss_n;
    err_nxt   = 1'b0;
    wrt_nxt   = 1'b0;
    found     = 1'b0;
    win       = '0;
    j         = 0;

    // Scan starting at ptr, which always sits one past the last winner.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = OW'(j);
      end
    end
    sel = req_ss[32'(win)*SS_W +: SS_W];

    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt    = win;
          ptr_nxt      = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          gnt_nxt[win] = 1'b1;
          cmd_nxt      = req_cmd[32'(win)*CMD_W +: CMD_W];
          state_nxt    = SEL;
          if (32'(sel) < NUM_SS) begin
            bad_nxt = 1'b0;
            for (int unsigned s = 0; s < NUM_SS; s++)
              if (32'(sel) == s) ss_nxt[s] = 1'b0;
          end else begin
            bad_nxt = 1'b1;
            err_nxt = 1'b1;
          end
        end
      end
      SEL: begin
        // An invalid select skips the SPI entirely and just completes.
        if (bad) begin
          done_nxt[owner] = 1'b1;
          state_nxt       = IDLE;
        end else begin
          wrt_nxt   = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (SPI_done) begin
          rd_nxt          = SPI_data_out;
          done_nxt[owner] = 1'b1;
          ss_nxt          = '1;
          if (GUARD > 0) begin
            state_nxt = GAP;
            cnt_nxt   = GW'(GUARD - 1);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      bad     <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      rd_data <= '0;
      SPI_cmd <= '0;
      ss_n    <= '1;
      err     <= 1'b0;
      wrt_SPI <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      bad     <= bad_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      rd_data <= rd_nxt;
      SPI_cmd <= cmd_nxt;
      ss_n    <= ss_nxt;
      err     <= err_nxt;
      wrt_SPI <= wrt_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_spi_xact_arb.sv
// Directed bench for spi_xact_arb: default instance (GUARD=2) plus a GUARD=0 instance.
module tb_spi_xact_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [5:0]  req_ss;
  logic [31:0] req_cmd;
  logic [1:0]  gnt, done;
  logic [15:0] rd_data, SPI_cmd, SPI_data_out;
  logic        err, busy, wrt_SPI, SPI_done;
  logic [4:0]  ss_n;

  logic [1:0]  g_req;
  logic [5:0]  g_req_ss;
  logic [31:0] g_req_cmd;
  logic [1:0]  g_gnt, g_done;
  logic [15:0] g_rd_data, g_SPI_cmd, g_SPI_data_out;
  logic        g_err, g_busy, g_wrt_SPI, g_SPI_done;
  logic [4:0]  g_ss_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_xact_arb u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_ss(req_ss), .req_cmd(req_cmd),
    .gnt(gnt), .done(done), .rd_data(rd_data), .err(err), .busy(busy),
    .wrt_SPI(wrt_SPI), .SPI_cmd(SPI_cmd), .SPI_done(SPI_done),
    .SPI_data_out(SPI_data_out), .ss_n(ss_n)
  );

  spi_xact_arb #(.GUARD(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .req(g_req), .req_ss(g_req_ss), .req_cmd(g_req_cmd),
    .gnt(g_gnt), .done(g_done), .rd_data(g_rd_data), .err(g_err), .busy(g_busy),
    .wrt_SPI(g_wrt_SPI), .SPI_cmd(g_SPI_cmd), .SPI_done(g_SPI_done),
    .SPI_data_out(g_SPI_data_out), .ss_n(g_ss_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; req_ss = '0; req_cmd = '0; SPI_done = 1'b0; SPI_data_out = '0;
    g_req = '0; g_req_ss = '0; g_req_cmd = '0; g_SPI_done = 1'b0; g_SPI_data_out = '0;
    step(); step();
    chk("rst_ss_n", 32'(ss_n), 32'h1f);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt_done_err_wrt", 32'({gnt, done, err, wrt_SPI}), 0);
    chk("rst_cmd_rd", 32'({SPI_cmd, rd_data}), 0);
    rst_n = 1'b1;
    step();

    // Single request to select 1
    req = 2'b01; req_ss = {3'd0, 3'd1}; req_cmd = {16'h0000, 16'hA5C3};
    step();
    chk("t1_gnt", 32'(gnt), 32'b01);
    chk("t1_ss_sel", 32'(ss_n), 32'b11101);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_wrt_early", 32'(wrt_SPI), 0);
    req = 2'b00; req_ss = {3'd4, 3'd3}; req_cmd = 32'hDEAD_BEEF;
    step();
    chk("t1_wrt", 32'(wrt_SPI), 1);
    chk("t1_cmd", 32'(SPI_cmd), 32'hA5C3);
    chk("t1_ss_stable", 32'(ss_n), 32'b11101);
    step();
    chk("t1_wrt_pulse", 32'(wrt_SPI), 0);
    chk("t1_xfer_stable", 32'({ss_n, SPI_cmd}), 32'({5'b11101, 16'hA5C3}));
    SPI_done = 1'b1; SPI_data_out = 16'h1234;
    step();
    chk("t1_rd", 32'(rd_data), 32'h1234);
    chk("t1_done", 32'(done), 32'b01);
    chk("t1_ss_release", 32'(ss_n), 32'h1f);
    // Stray SPI_done during GAP and then in IDLE
    SPI_data_out = 16'hBEEF;
    step();
    chk("gap_busy", 32'(busy), 1);
    chk("gap_stray_done", 32'(done), 0);
    chk("gap_stray_rd", 32'(rd_data), 32'h1234);
    step();
    chk("gap_end_busy", 32'(busy), 0);
    step();
    chk("idle_stray_done", 32'(done), 0);
    chk("idle_stray_rd", 32'(rd_data), 32'h1234);
    SPI_done = 1'b0;

    // Invalid select 7
    req = 2'b01; req_ss = {3'd0, 3'd7};
    step();
    chk("inv_gnt", 32'(gnt), 32'b01);
    chk("inv_err", 32'(err), 1);
    chk("inv_ss", 32'(ss_n), 32'h1f);
    req = 2'b00;
    step();
    chk("inv_done", 32'(done), 32'b01);
    chk("inv_wrt", 32'(wrt_SPI), 0);
    chk("inv_err_pulse", 32'(err), 0);
    chk("inv_rd", 32'(rd_data), 32'h1234);
    step();
    chk("inv_idle", 32'({busy, done, wrt_SPI}), 0);

    // Reset during XFER
    req = 2'b01; req_ss = {3'd0, 3'd0}; req_cmd = {16'h0000, 16'h5555};
    step();
    req = 2'b00;
    step();
    step();
    chk("rx_ss_xfer", 32'(ss_n), 32'b11110);
    rst_n = 1'b0;
    #1;
    chk("rx_ss_async", 32'(ss_n), 32'h1f);
    step();
    SPI_done = 1'b1;
    step();
    chk("rx_no_done", 32'(done), 0);
    SPI_done = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rx_idle", 32'({busy, done, ss_n}), 32'h1f);

    // Contention: both held, grants must alternate 0,1,0,1 from the reset pointer
    req = 2'b11; req_ss = {3'd2, 3'd0}; req_cmd = {16'h2222, 16'h1111};
    for (int n = 0; n < 4; n++) begin
      step();
      chk("ct_gnt", 32'(gnt), (n % 2 == 0) ? 32'b01 : 32'b10);
      chk("ct_ss", 32'(ss_n), (n % 2 == 0) ? 32'b11110 : 32'b11011);
      step();
      chk("ct_cmd", 32'({wrt_SPI, SPI_cmd}), (n % 2 == 0) ? 32'h1_1111 : 32'h1_2222);
      step();
      SPI_done = 1'b1; SPI_data_out = 16'(16'hC000 + n);
      step();
      SPI_done = 1'b0;
      chk("ct_done", 32'(done), (n % 2 == 0) ? 32'b01 : 32'b10);
      chk("ct_rd", 32'(rd_data), 32'(16'hC000 + n));
      if (n == 3) req = 2'b00;
      step();
      chk("ct_gap", 32'({gnt, busy, ss_n}), 32'({2'b00, 1'b1, 5'h1f}));
      step();
      chk("ct_gap_end", 32'({gnt, busy, ss_n}), 32'({2'b00, 1'b0, 5'h1f}));
    end

    // GUARD=0: next grant one edge after the SPI_done edge, same requester re-arbitrated
    g_req = 2'b01; g_req_ss = {3'd0, 3'd1}; g_req_cmd = {16'h0000, 16'h7777};
    step();
    chk("g0_gnt", 32'(g_gnt), 32'b01);
    g_req = 2'b00;
    step();
    chk("g0_wrt", 32'(g_wrt_SPI), 1);
    step();
    g_SPI_done = 1'b1; g_SPI_data_out = 16'h4321; g_req = 2'b01;
    step();
    g_SPI_done = 1'b0;
    chk("g0_done", 32'(g_done), 32'b01);
    chk("g0_idle", 32'({g_busy, g_ss_n}), 32'h1f);
    step();
    chk("g0_regnt", 32'(g_gnt), 32'b01);
    g_req = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
